// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-port memory between fetch (I) and load/store (D) and sequences
// issue / fixed read latency / completion. Define MEMARB_RR_EN for round-robin on ties.
module mem_port_arbiter #(
    parameter int MEM_LAT = 2,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              I_req,
    input  logic [ADDR_W-1:0] I_addr,
    output logic [DATA_W-1:0] I_rdata,
    output logic              I_done,
    input  logic              D_req,
    input  logic              D_wr,
    input  logic [ADDR_W-1:0] D_addr,
    input  logic [DATA_W-1:0] D_wdata,
    output logic [DATA_W-1:0] D_rdata,
    output logic              D_done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [1:0]        owner,
    output logic              busy
);
    localparam int CNT_W = $clog2(MEM_LAT + 1);
    localparam logic [1:0] OWN_NONE = 2'b00;
    localparam logic [1:0] OWN_I    = 2'b01;
    localparam logic [1:0] OWN_D    = 2'b10;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        owner_q, owner_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              wr_q, wr_d;
    logic [DATA_W-1:0] ird_q, ird_d;
    logic [DATA_W-1:0] drd_q, drd_d;
    logic              pick_d;

`ifdef MEMARB_RR_EN
    logic [1:0] last_q, last_d;
    // On a tie, the port that did not win last time gets the grant.
    assign pick_d = D_req && (!I_req || (last_q != OWN_D));
`else
    assign pick_d = D_req;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        owner_d = owner_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wr_d    = 1'b0;
        ird_d   = ird_q;
        drd_d   = drd_q;
`ifdef MEMARB_RR_EN
        last_d  = last_q;
`endif
        case (state_q)
            IDLE: begin
                if (I_req || D_req) begin
                    state_d = ISSUE;
                    if (pick_d) begin
                        owner_d = OWN_D;
                        addr_d  = D_addr;
                        wdata_d = D_wdata;
                        wr_d    = D_wr;
                    end else begin
                        owner_d = OWN_I;
                        addr_d  = I_addr;
                    end
`ifdef MEMARB_RR_EN
                    last_d = owner_d;
`endif
                end
            end
            ISSUE: begin
                // wr_q is high only in ISSUE of a write, so it doubles as the txn type.
                if (wr_q) begin
                    state_d = DONE;
                end else begin
                    cnt_d   = CNT_W'(MEM_LAT);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = DONE;
                    if (owner_q == OWN_D) drd_d = mem_rdata;
                    else                  ird_d = mem_rdata;
                end
            end
            DONE: begin
                state_d = IDLE;
                owner_d = OWN_NONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            owner_q <= OWN_NONE;
            addr_q  <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
            ird_q   <= '0;
            drd_q   <= '0;
`ifdef MEMARB_RR_EN
            last_q  <= OWN_I;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            owner_q <= owner_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wr_q    <= wr_d;
            ird_q   <= ird_d;
            drd_q   <= drd_d;
`ifdef MEMARB_RR_EN
            last_q  <= last_d;
`endif
        end
    end

    assign mem_addr  = addr_q;
    assign mem_wr    = wr_q;
    assign mem_wdata = wdata_q;
    assign I_rdata   = ird_q;
    assign D_rdata   = drd_q;
    assign owner     = owner_q;
    assign busy      = (state_q != IDLE);
    assign I_done    = (state_q == DONE) && (owner_q == OWN_I);
    assign D_done    = (state_q == DONE) && (owner_q == OWN_D);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed transactions push expected completions
// and write strobes; negedge monitors pop and compare.
module tb_mem_port_arbiter;
    localparam int MEM_LAT = 2;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        I_req, D_req, D_wr;
    logic [31:0] I_addr, D_addr, D_wdata;
    logic [31:0] I_rdata, D_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        I_done, D_done, mem_wr, busy;
    logic [1:0]  owner;

    mem_port_arbiter #(.MEM_LAT(MEM_LAT), .ADDR_W(32), .DATA_W(32)) dut (
        .Clk(Clk), .Reset(Reset),
        .I_req(I_req), .I_addr(I_addr), .I_rdata(I_rdata), .I_done(I_done),
        .D_req(D_req), .D_wr(D_wr), .D_addr(D_addr), .D_wdata(D_wdata),
        .D_rdata(D_rdata), .D_done(D_done),
        .mem_addr(mem_addr), .mem_wr(mem_wr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .owner(owner), .busy(busy)
    );

    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Memory model: data only valid exactly MEM_LAT cycles after a new address is issued.
    logic [31:0] mem [0:255];
    logic [31:0] apipe [MEM_LAT];
    logic [MEM_LAT-1:0] vpipe = '0;
    logic busy_prev = 1'b0;
    always @(posedge Clk) begin
        busy_prev <= busy;
        apipe[0]  <= mem_addr;
        for (int k = 1; k < MEM_LAT; k++) apipe[k] <= apipe[k-1];
        vpipe <= {vpipe[MEM_LAT-2:0], busy && !busy_prev};
        if (mem_wr) mem[mem_addr[7:0]] <= mem_wdata;
    end
    assign mem_rdata = vpipe[MEM_LAT-1] ? mem[apipe[MEM_LAT-1][7:0]] : 32'hBADBAD00;

    typedef struct {
        bit          is_d;
        bit          chk_rd;
        logic [31:0] rdata;
        int          cyc;
    } exp_t;
    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          cyc;
    } wexp_t;

    exp_t  expq[$];
    wexp_t wq[$];
    exp_t  e;
    wexp_t w;

    always @(negedge Clk) begin
        if (I_done || D_done) begin
            chk("done_onehot", {63'd0, I_done & D_done}, 64'd0);
            if (expq.size() == 0) begin
                chk("unexpected_done", {62'd0, D_done, I_done}, 64'd0);
            end else begin
                e = expq.pop_front();
                chk("done_port", {62'd0, D_done, I_done}, e.is_d ? 64'd2 : 64'd1);
                chk("done_cycle", cyc, e.cyc);
                chk("done_owner", {62'd0, owner}, e.is_d ? 64'd2 : 64'd1);
                if (e.chk_rd) chk("rdata", e.is_d ? D_rdata : I_rdata, e.rdata);
            end
        end
        if (mem_wr) begin
            if (wq.size() == 0) begin
                chk("unexpected_mem_wr", {63'd0, mem_wr}, 64'd0);
            end else begin
                w = wq.pop_front();
                chk("wr_addr", mem_addr, w.addr);
                chk("wr_data", mem_wdata, w.data);
                chk("wr_cycle", cyc, w.cyc);
            end
        end
    end

    bit drop_i = 1'b1, drop_d = 1'b1;

    // Waits for n completions; drops a request in its done cycle when enabled.
    task automatic wait_done(input int n, input int budget);
        int got = 0;
        for (int c = 0; c < budget && got < n; c++) begin
            @(negedge Clk);
            if (I_done) begin got++; if (drop_i) I_req = 1'b0; end
            if (D_done) begin got++; if (drop_d) D_req = 1'b0; end
        end
        if (got < n) begin
            chk("timeout", got, n);
            I_req = 1'b0;
            D_req = 1'b0;
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    int t0;

    initial begin
        for (int k = 0; k < 256; k++) mem[k] = 32'h0;
        mem[8'h10] = 32'hDEADBEEF;
        mem[8'h20] = 32'hCAFEF00D;
        mem[8'h30] = 32'h0BADF00D;
        Reset = 1'b1; I_req = 1'b1; D_req = 1'b1; D_wr = 1'b0;
        I_addr = 32'h10; D_addr = 32'h20; D_wdata = 32'h0;

        // Reset held 3 cycles with both requests high
        for (int k = 0; k < 3; k++) begin
            @(negedge Clk);
            chk("rst_busy", {63'd0, busy}, 64'd0);
            chk("rst_owner", {62'd0, owner}, 64'd0);
            chk("rst_mem_wr", {63'd0, mem_wr}, 64'd0);
            chk("rst_mem_addr", mem_addr, 64'd0);
            chk("rst_mem_wdata", mem_wdata, 64'd0);
            chk("rst_rdata", {I_rdata, D_rdata}, 64'd0);
        end
        I_req = 1'b0; D_req = 1'b0;
        step();
        Reset = 1'b0;
        step();

        // D write 0x40 <= 0x12345678
        t0 = cyc;
        D_req = 1'b1; D_wr = 1'b1; D_addr = 32'h40; D_wdata = 32'h12345678;
        wq.push_back('{addr: 32'h40, data: 32'h12345678, cyc: t0 + 1});
        expq.push_back('{is_d: 1'b1, chk_rd: 1'b0, rdata: 32'h0, cyc: t0 + 2});
        wait_done(1, 20);
        step();

        // D read back 0x40
        t0 = cyc;
        D_req = 1'b1; D_wr = 1'b0; D_addr = 32'h40;
        expq.push_back('{is_d: 1'b1, chk_rd: 1'b1, rdata: 32'h12345678, cyc: t0 + 4});
        wait_done(1, 20);
        step();

        // I read 0x10
        t0 = cyc;
        I_req = 1'b1; I_addr = 32'h10;
        expq.push_back('{is_d: 1'b0, chk_rd: 1'b1, rdata: 32'hDEADBEEF, cyc: t0 + 4});
        wait_done(1, 20);
        step();

        // Tie: D read 0x20 first, I read 0x10 after one IDLE cycle
        t0 = cyc;
        I_req = 1'b1; I_addr = 32'h10;
        D_req = 1'b1; D_wr = 1'b0; D_addr = 32'h20;
        expq.push_back('{is_d: 1'b1, chk_rd: 1'b1, rdata: 32'hCAFEF00D, cyc: t0 + 4});
        expq.push_back('{is_d: 1'b0, chk_rd: 1'b1, rdata: 32'hDEADBEEF, cyc: t0 + 9});
        wait_done(2, 30);
        step();

        // Both held for 4 transactions
        t0 = cyc;
        I_req = 1'b1; I_addr = 32'h10;
        D_req = 1'b1; D_wr = 1'b0; D_addr = 32'h30;
        drop_i = 1'b0; drop_d = 1'b0;
        for (int k = 0; k < 4; k++) begin
`ifdef MEMARB_RR_EN
            expq.push_back('{is_d: (k % 2 == 0), chk_rd: 1'b1,
                             rdata: (k % 2 == 0) ? 32'h0BADF00D : 32'hDEADBEEF, cyc: t0 + 4 + 5 * k});
`else
            expq.push_back('{is_d: 1'b1, chk_rd: 1'b1, rdata: 32'h0BADF00D, cyc: t0 + 4 + 5 * k});
`endif
        end
        wait_done(4, 60);
        I_req = 1'b0; D_req = 1'b0;
        drop_i = 1'b1; drop_d = 1'b1;
        step();

        // Reset during WAIT of a D read; request stays up and completes afterwards
        t0 = cyc;
        D_req = 1'b1; D_wr = 1'b0; D_addr = 32'h20;
        step();
        step();
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        chk("mid_rst_busy", {63'd0, busy}, 64'd0);
        chk("mid_rst_owner", {62'd0, owner}, 64'd0);
        chk("mid_rst_mem_wr", {63'd0, mem_wr}, 64'd0);
        chk("mid_rst_D_rdata", D_rdata, 64'd0);
        chk("mid_rst_I_rdata", I_rdata, 64'd0);
        expq.push_back('{is_d: 1'b1, chk_rd: 1'b1, rdata: 32'hCAFEF00D, cyc: t0 + 7});
        wait_done(1, 20);

        repeat (4) step();
        chk("exp_left", expq.size(), 64'd0);
        chk("wr_left", wq.size(), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
